// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Contents: arbiter state enum, owner encoding, default address/data widths
// and the default watchdog limit.
package riscv_mem_pkg;

   localparam int unsigned ADDR_W          = 64;
   localparam int unsigned DATA_W          = 64;
   localparam int unsigned INSN_W          = 32;
   localparam int unsigned TIMEOUT_DEFAULT = 255;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ERR   = 2'd3
   } mem_arb_state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter (fetch vs. load/store).
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   req_i, req_d    - request lines from the fetch and data requesters
//   accept          - a grant was taken this cycle; updates last_grant
//   gnt_i, gnt_d    - combinational one-hot grant
module rr_arb2
   import riscv_mem_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_i,
   input  logic req_d,
   input  logic accept,
   output logic gnt_i,
   output logic gnt_d
);

   owner_t last_grant;

   // On a tie the requester that did not win last time is chosen.
   always_comb begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
      if (req_i && req_d) begin
         gnt_i = (last_grant == OWN_D);
         gnt_d = (last_grant == OWN_I);
      end else begin
         gnt_i = req_i;
         gnt_d = req_d;
      end
   end

   // Resets to D so the fetch side wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= OWN_D;
      end else if (accept) begin
         last_grant <= gnt_d ? OWN_D : OWN_I;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single unified memory port between instruction fetch (I) and
// load/store (D). One transaction outstanding at a time; round-robin on
// contention; watchdog turns a hung response into an error completion.
// Ports:
//   clk, rst                         - clock, asynchronous active-high reset
//   i_req_valid/ready, i_addr        - fetch request
//   i_resp_valid/data/err            - fetch response (32-bit instruction)
//   d_req_valid/ready, d_addr, d_we,
//   d_wdata, d_wstrb                 - load/store request
//   d_resp_valid/data/err            - load/store response
//   mem_req_valid/ready, mem_addr,
//   mem_we, mem_wdata, mem_wstrb     - memory request (doubleword aligned)
//   mem_resp_valid, mem_resp_data    - memory response
//   busy                             - a transaction is in flight
module mem_port_arbiter #(
   parameter int unsigned ADDR_W  = riscv_mem_pkg::ADDR_W,
   parameter int unsigned DATA_W  = riscv_mem_pkg::DATA_W,
   parameter int unsigned TIMEOUT = riscv_mem_pkg::TIMEOUT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req_valid,
   output logic                  i_req_ready,
   input  logic [ADDR_W-1:0]     i_addr,
   output logic                  i_resp_valid,
   output logic [31:0]           i_resp_data,
   output logic                  i_resp_err,
   input  logic                  d_req_valid,
   output logic                  d_req_ready,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic                  d_we,
   input  logic [DATA_W-1:0]     d_wdata,
   input  logic [DATA_W/8-1:0]   d_wstrb,
   output logic                  d_resp_valid,
   output logic [DATA_W-1:0]     d_resp_data,
   output logic                  d_resp_err,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic                  mem_we,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wstrb,
   input  logic                  mem_resp_valid,
   input  logic [DATA_W-1:0]     mem_resp_data,
   output logic                  busy
);

   import riscv_mem_pkg::*;

   localparam int unsigned     WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   mem_arb_state_t        state, state_n;
   owner_t                owner_q;
   logic [ADDR_W-1:0]     addr_q;
   logic                  we_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [DATA_W/8-1:0]   wstrb_q;
   logic [WD_W-1:0]       wd_q;
   logic                  gnt_i, gnt_d, accept;
   logic                  unused_addr_lsb;

   // Byte offset within the word is never forwarded to memory.
   assign unused_addr_lsb = ^addr_q[1:0];

   assign accept = (state == IDLE) && (gnt_i || gnt_d);
   assign busy   = (state != IDLE);

   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req_i  (i_req_valid),
      .req_d  (d_req_valid),
      .accept (accept),
      .gnt_i  (gnt_i),
      .gnt_d  (gnt_d)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Request capture; fetches carry no write fields.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q <= OWN_I;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else if (accept) begin
         owner_q <= gnt_i ? OWN_I : OWN_D;
         addr_q  <= gnt_i ? i_addr : d_addr;
         we_q    <= gnt_d && d_we;
         wdata_q <= gnt_d ? d_wdata : '0;
         wstrb_q <= gnt_d ? d_wstrb : '0;
      end
   end

   // Watchdog counts WAIT cycles; cleared everywhere else.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                wd_q <= '0;
      else if (state == WAIT) wd_q <= wd_q + 1'b1;
      else                    wd_q <= '0;
   end

   // Next state and all port outputs.
   always_comb begin
      state_n       = state;
      i_req_ready   = 1'b0;
      d_req_ready   = 1'b0;
      mem_req_valid = 1'b0;
      mem_addr      = '0;
      mem_we        = 1'b0;
      mem_wdata     = '0;
      mem_wstrb     = '0;
      i_resp_valid  = 1'b0;
      i_resp_data   = '0;
      i_resp_err    = 1'b0;
      d_resp_valid  = 1'b0;
      d_resp_data   = '0;
      d_resp_err    = 1'b0;
      case (state)
         IDLE: begin
            i_req_ready = gnt_i;
            d_req_ready = gnt_d;
            // Misaligned fetch completes with an error and never touches memory.
            if (gnt_i)      state_n = (i_addr[1:0] != 2'b00) ? ERR : ISSUE;
            else if (gnt_d) state_n = ISSUE;
         end
         ISSUE: begin
            mem_req_valid = 1'b1;
            mem_addr      = {addr_q[ADDR_W-1:3], 3'b000};
            mem_we        = we_q;
            mem_wdata     = wdata_q;
            mem_wstrb     = wstrb_q;
            if (mem_req_ready) state_n = WAIT;
         end
         WAIT: begin
            // A response arriving on the last watchdog cycle still wins.
            if (mem_resp_valid || (wd_q == WD_LAST)) begin
               state_n = IDLE;
               if (owner_q == OWN_I) begin
                  i_resp_valid = 1'b1;
                  i_resp_err   = !mem_resp_valid;
                  if (mem_resp_valid)
                     i_resp_data = addr_q[2] ? mem_resp_data[63:32] : mem_resp_data[31:0];
               end else begin
                  d_resp_valid = 1'b1;
                  d_resp_err   = !mem_resp_valid;
                  if (mem_resp_valid)
                     d_resp_data = mem_resp_data;
               end
            end
         end
         ERR: begin
            i_resp_valid = 1'b1;
            i_resp_err   = 1'b1;
            state_n      = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (TIMEOUT overridden to 8).
module tb_mem_port_arbiter;

   localparam int unsigned TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req_valid, i_req_ready, i_resp_valid, i_resp_err;
   logic [63:0] i_addr;
   logic [31:0] i_resp_data;
   logic        d_req_valid, d_req_ready, d_we, d_resp_valid, d_resp_err;
   logic [63:0] d_addr, d_wdata, d_resp_data;
   logic [7:0]  d_wstrb;
   logic        mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
   logic [63:0] mem_addr, mem_wdata, mem_resp_data;
   logic [7:0]  mem_wstrb;
   logic        busy;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
      .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data), .i_resp_err(i_resp_err),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
      .d_we(d_we), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .busy(busy)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_req_valid = 1'b0; i_addr = '0;
      d_req_valid = 1'b0; d_addr = '0; d_we = 1'b0; d_wdata = '0; d_wstrb = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (2) cyc();
      @(negedge clk);
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %h want 0", busy); end
      vecs++; if ({i_req_ready, d_req_ready} !== 2'b00) begin errs++; $display("FAIL rst_ready: got %b want 00", {i_req_ready, d_req_ready}); end
      vecs++; if ({mem_req_valid, mem_we, mem_wstrb, mem_addr, mem_wdata} !== '0) begin errs++; $display("FAIL rst_mem: valid %h addr %h want all 0", mem_req_valid, mem_addr); end
      vecs++; if ({i_resp_valid, i_resp_err, i_resp_data, d_resp_valid, d_resp_err, d_resp_data} !== '0) begin errs++; $display("FAIL rst_resp: iv %h dv %h want 0", i_resp_valid, d_resp_valid); end
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_fetch_aligned();
      i_req_valid = 1'b1; i_addr = 64'h1004;
      @(negedge clk);
      vecs++; if ({i_req_ready, d_req_ready} !== 2'b10) begin errs++; $display("FAIL fetch_ready: got %b want 10", {i_req_ready, d_req_ready}); end
      cyc();
      i_req_valid = 1'b0; i_addr = 64'hFFFF_FFF0; mem_req_ready = 1'b1;
      @(negedge clk);
      vecs++; if (mem_req_valid !== 1'b1) begin errs++; $display("FAIL fetch_issue: got %h want 1", mem_req_valid); end
      vecs++; if (mem_addr !== 64'h1000) begin errs++; $display("FAIL fetch_addr: got %h want 1000", mem_addr); end
      vecs++; if ({mem_we, mem_wstrb} !== 9'h0) begin errs++; $display("FAIL fetch_we: got %h want 0", {mem_we, mem_wstrb}); end
      cyc();
      mem_req_ready = 1'b0;
      @(negedge clk);
      vecs++; if ({mem_req_valid, i_resp_valid} !== 2'b00) begin errs++; $display("FAIL fetch_wait1: got %b want 00", {mem_req_valid, i_resp_valid}); end
      cyc();
      cyc();
      mem_resp_valid = 1'b1; mem_resp_data = 64'hAAAA_BBBB_1111_2222;
      @(negedge clk);
      vecs++; if ({i_resp_valid, i_resp_err, d_resp_valid} !== 3'b100) begin errs++; $display("FAIL fetch_strobe: got %b want 100", {i_resp_valid, i_resp_err, d_resp_valid}); end
      vecs++; if (i_resp_data !== 32'hAAAA_BBBB) begin errs++; $display("FAIL fetch_data: got %h want aaaabbbb", i_resp_data); end
      cyc();
      mem_resp_valid = 1'b0;
      @(negedge clk);
      vecs++; if ({busy, i_resp_valid, i_resp_data} !== 34'h0) begin errs++; $display("FAIL fetch_done: busy %h iv %h data %h want 0", busy, i_resp_valid, i_resp_data); end
      cyc();
   endtask

   task automatic test_back_to_back();
      logic exp_d;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      i_req_valid = 1'b1; i_addr = 64'h2000;
      d_req_valid = 1'b1; d_addr = 64'h3000; d_we = 1'b0;
      mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 64'h1111_2222_3333_4444;
      for (int t = 0; t < 4; t++) begin
         exp_d = ((t % 2) == 1);
         @(negedge clk);
         vecs++; if ({i_req_ready, d_req_ready} !== {!exp_d, exp_d}) begin errs++; $display("FAIL rr_grant%0d: got %b want %b", t, {i_req_ready, d_req_ready}, {!exp_d, exp_d}); end
         cyc();
         @(negedge clk);
         vecs++; if (mem_addr !== (exp_d ? 64'h3000 : 64'h2000) || mem_req_valid !== 1'b1) begin errs++; $display("FAIL rr_issue%0d: got %h/%h", t, mem_req_valid, mem_addr); end
         cyc();
         @(negedge clk);
         vecs++; if ({i_resp_valid, d_resp_valid} !== {!exp_d, exp_d}) begin errs++; $display("FAIL rr_resp%0d: got %b want %b", t, {i_resp_valid, d_resp_valid}, {!exp_d, exp_d}); end
         if (exp_d) begin
            vecs++; if (d_resp_data !== 64'h1111_2222_3333_4444) begin errs++; $display("FAIL rr_ddata%0d: got %h", t, d_resp_data); end
         end else begin
            vecs++; if (i_resp_data !== 32'h3333_4444) begin errs++; $display("FAIL rr_idata%0d: got %h want 33334444", t, i_resp_data); end
         end
         cyc();
      end
      idle_inputs();
   endtask

   task automatic test_store_stall();
      d_req_valid = 1'b1; d_addr = 64'h2008; d_we = 1'b1;
      d_wdata = 64'h0123_4567_89AB_CDEF; d_wstrb = 8'h0F;
      @(negedge clk);
      vecs++; if ({i_req_ready, d_req_ready} !== 2'b01) begin errs++; $display("FAIL st_ready: got %b want 01", {i_req_ready, d_req_ready}); end
      cyc();
      d_req_valid = 1'b0; d_addr = '0; d_we = 1'b0; d_wdata = '0; d_wstrb = '0;
      for (int s = 0; s < 5; s++) begin
         mem_req_ready = (s == 4);
         @(negedge clk);
         vecs++; if ({mem_req_valid, mem_we, mem_wstrb} !== 10'h30F) begin errs++; $display("FAIL st_ctl%0d: got %h want 30f", s, {mem_req_valid, mem_we, mem_wstrb}); end
         vecs++; if (mem_addr !== 64'h2008) begin errs++; $display("FAIL st_addr%0d: got %h want 2008", s, mem_addr); end
         vecs++; if (mem_wdata !== 64'h0123_4567_89AB_CDEF) begin errs++; $display("FAIL st_wdata%0d: got %h", s, mem_wdata); end
         cyc();
      end
      mem_req_ready = 1'b0;
      @(negedge clk);
      vecs++; if ({mem_req_valid, d_resp_valid} !== 2'b00) begin errs++; $display("FAIL st_wait: got %b want 00", {mem_req_valid, d_resp_valid}); end
      cyc();
      mem_resp_valid = 1'b1; mem_resp_data = 64'h5555;
      @(negedge clk);
      vecs++; if ({d_resp_valid, d_resp_err, i_resp_valid} !== 3'b100) begin errs++; $display("FAIL st_ack: got %b want 100", {d_resp_valid, d_resp_err, i_resp_valid}); end
      vecs++; if (d_resp_data !== 64'h5555) begin errs++; $display("FAIL st_rdata: got %h want 5555", d_resp_data); end
      cyc();
      idle_inputs();
   endtask

   task automatic test_misaligned();
      i_req_valid = 1'b1; i_addr = 64'h1002; mem_resp_data = '1;
      @(negedge clk);
      vecs++; if (i_req_ready !== 1'b1) begin errs++; $display("FAIL mis_ready: got %h want 1", i_req_ready); end
      cyc();
      i_req_valid = 1'b0;
      @(negedge clk);
      vecs++; if ({mem_req_valid, i_resp_valid, i_resp_err, busy} !== 4'b0111) begin errs++; $display("FAIL mis_strobe: got %b want 0111", {mem_req_valid, i_resp_valid, i_resp_err, busy}); end
      vecs++; if (i_resp_data !== 32'h0) begin errs++; $display("FAIL mis_data: got %h want 0", i_resp_data); end
      cyc();
      @(negedge clk);
      vecs++; if ({mem_req_valid, i_resp_valid, busy} !== 3'b000) begin errs++; $display("FAIL mis_done: got %b want 000", {mem_req_valid, i_resp_valid, busy}); end
      cyc();
      idle_inputs();
   endtask

   task automatic test_timeout();
      d_req_valid = 1'b1; d_addr = 64'h4000;
      @(negedge clk);
      vecs++; if (d_req_ready !== 1'b1) begin errs++; $display("FAIL to_ready: got %h want 1", d_req_ready); end
      cyc();
      d_req_valid = 1'b0; mem_req_ready = 1'b1;
      @(negedge clk);
      vecs++; if (mem_req_valid !== 1'b1) begin errs++; $display("FAIL to_issue: got %h want 1", mem_req_valid); end
      cyc();
      mem_req_ready = 1'b0; mem_resp_data = 64'hBAD0_BAD0_BAD0_BAD0;
      for (int w = 1; w <= int'(TO); w++) begin
         @(negedge clk);
         vecs++; if (d_resp_valid !== (w == int'(TO))) begin errs++; $display("FAIL to_strobe_w%0d: got %h", w, d_resp_valid); end
         if (w == int'(TO)) begin
            vecs++; if ({d_resp_err, d_resp_data} !== {1'b1, 64'h0}) begin errs++; $display("FAIL to_err: err %h data %h want 1/0", d_resp_err, d_resp_data); end
         end
         cyc();
      end
      mem_resp_valid = 1'b1; mem_resp_data = 64'h7777;
      @(negedge clk);
      vecs++; if ({d_resp_valid, i_resp_valid, busy, mem_req_valid} !== 4'b0000) begin errs++; $display("FAIL to_late: got %b want 0000", {d_resp_valid, i_resp_valid, busy, mem_req_valid}); end
      cyc();
      mem_resp_valid = 1'b0;
      d_req_valid = 1'b1; d_addr = 64'h4010;
      @(negedge clk);
      vecs++; if (d_req_ready !== 1'b1) begin errs++; $display("FAIL to_next_ready: got %h want 1", d_req_ready); end
      cyc();
      d_req_valid = 1'b0; mem_req_ready = 1'b1;
      @(negedge clk);
      vecs++; if (mem_addr !== 64'h4010) begin errs++; $display("FAIL to_next_addr: got %h want 4010", mem_addr); end
      cyc();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h0123_4567_0000_0042;
      @(negedge clk);
      vecs++; if ({d_resp_valid, d_resp_err} !== 2'b10 || d_resp_data !== 64'h0123_4567_0000_0042) begin errs++; $display("FAIL to_next_resp: v/e %b data %h", {d_resp_valid, d_resp_err}, d_resp_data); end
      cyc();
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      i_req_valid = 1'b1; i_addr = 64'h5004;
      cyc();
      i_req_valid = 1'b0; mem_req_ready = 1'b1;
      cyc();
      mem_req_ready = 1'b0;
      @(negedge clk);
      vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL rm_inflight: got %h want 1", busy); end
      cyc();
      rst = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 64'h9999_8888_7777_6666;
      #1;
      vecs++; if ({busy, i_resp_valid, i_resp_err, i_resp_data, mem_req_valid, i_req_ready} !== '0) begin errs++; $display("FAIL rm_async: busy %h iv %h data %h", busy, i_resp_valid, i_resp_data); end
      cyc();
      rst = 1'b0; mem_resp_valid = 1'b0;
      @(negedge clk);
      vecs++; if ({busy, i_resp_valid, d_resp_valid} !== 3'b000) begin errs++; $display("FAIL rm_stale: got %b want 000", {busy, i_resp_valid, d_resp_valid}); end
      cyc();
      i_req_valid = 1'b1; i_addr = 64'h6000;
      @(negedge clk);
      vecs++; if (i_req_ready !== 1'b1) begin errs++; $display("FAIL rm_ready: got %h want 1", i_req_ready); end
      cyc();
      i_req_valid = 1'b0; mem_req_ready = 1'b1;
      @(negedge clk);
      vecs++; if (mem_addr !== 64'h6000) begin errs++; $display("FAIL rm_addr: got %h want 6000", mem_addr); end
      cyc();
      mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'hDEAD_BEEF_CAFE_F00D;
      @(negedge clk);
      vecs++; if ({i_resp_valid, i_resp_err} !== 2'b10 || i_resp_data !== 32'hCAFE_F00D) begin errs++; $display("FAIL rm_resp: v/e %b data %h want 10/cafef00d", {i_resp_valid, i_resp_err}, i_resp_data); end
      cyc();
      mem_resp_valid = 1'b0;
      @(negedge clk);
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rm_done: got %h want 0", busy); end
      cyc();
      idle_inputs();
   endtask

   initial begin
      #100000;
      $display("FAIL sim_timeout: run did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_fetch_aligned();
      test_back_to_back();
      test_store_stall();
      test_misaligned();
      test_timeout();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
